// File: rtl/demux1to4_seq_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer.
// Holds the shared input stream, the four output channels and their counters.
// The slave side is the demux; the master side is the producer/consumer environment.
`timescale 1ns/1ps
interface demux1to4_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             s0;
    logic             s1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    modport slave (
        input  in_data, s0, s1, in_valid, out_ready,
        output in_ready, out0, out1, out2, out3, out_valid, cnt0, cnt1, cnt2, cnt3
    );

    modport master (
        output in_data, s0, s1, in_valid, out_ready,
        input  in_ready, out0, out1, out2, out3, out_valid, cnt0, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/demux1to4_seq.sv
// Registered 1-to-4 demultiplexer.
// One valid/ready input stream is steered by {s0,s1} into one of four
// one-entry channel registers, each with its own handshake and transfer counter.
`timescale 1ns/1ps

// One output channel: a single-entry holding register plus a completed-transfer counter.
module demux1to4_ch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ordy,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic [CNT_W-1:0] cnt
);
    logic drain;

    // A consumer handshake only counts while a word is actually held.
    assign drain = vld & ordy;

    // Load wins over drain so a same-cycle drain+reload keeps the entry full with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            vld  <= 1'b0;
            cnt  <= '0;
        end else begin
            if (load) begin
                dout <= din;
                vld  <= 1'b1;
            end else if (drain) begin
                vld  <= 1'b0;
            end
            if (drain) cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module demux1to4_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    demux1to4_seq_if.slave   bus
);
    localparam int NUM_CH = 4;

    logic [1:0]                    sel;
    logic                          sel_x;
    logic [NUM_CH-1:0]             load;
    logic [NUM_CH-1:0][WIDTH-1:0]  dout;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0]             vld;

    assign sel   = {bus.s0, bus.s1};
    // Unknown select can never be resolved to a channel, so refuse the word; always 0 in hardware.
    assign sel_x = $isunknown({bus.s0, bus.s1});

    // Accept when the selected entry is empty or is being drained this same cycle.
    always_comb begin
        bus.in_ready = 1'b0;
        if (rst_n && !sel_x)
            bus.in_ready = ~vld[sel] | bus.out_ready[sel];
    end

    // Only the selected channel sees the load strobe.
    always_comb begin
        load = '0;
        if (bus.in_valid && bus.in_ready)
            load[sel] = 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        demux1to4_ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .din   (bus.in_data),
            .ordy  (bus.out_ready[i]),
            .dout  (dout[i]),
            .vld   (vld[i]),
            .cnt   (cnt[i])
        );
    end

    assign bus.out_valid = vld;
    assign bus.out0 = dout[0];
    assign bus.out1 = dout[1];
    assign bus.out2 = dout[2];
    assign bus.out3 = dout[3];
    assign bus.cnt0 = cnt[0];
    assign bus.cnt1 = cnt[1];
    assign bus.cnt2 = cnt[2];
    assign bus.cnt3 = cnt[3];
endmodule

// File: tb/tb_demux1to4_seq.sv
// Directed bench for demux1to4_seq: routing, backpressure, drain+reload,
// counter wrap, asynchronous reset mid-operation and held data after consume.
`timescale 1ns/1ps
module tb_demux1to4_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errs = 0;

    demux1to4_seq_if #(.WIDTH(8), .CNT_W(8)) bus ();

    demux1to4_seq #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.s0       = s[1];
        bus.s1       = s[0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 2'b00);
        bus.out_ready = 4'b0000;

        // ---- 1: reset then basic routing
        tick();
        drive(1'b1, 8'hA0, 2'b00);
        #1;
        chk("rst_valid", bus.out_valid, 4'b0000);
        chk("rst_cnt0", bus.cnt0, 8'h00);
        chk("rst_out3", bus.out3, 8'h00);
        chk("rst_inrdy", bus.in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 4'b1111;
        #1;
        chk("t1_rdy0", bus.in_ready, 1'b1);
        tick();
        chk("t1_vld0", bus.out_valid, 4'b0001);
        chk("t1_out0", bus.out0, 8'hA0);
        drive(1'b1, 8'hA1, 2'b01);
        #1;
        chk("t1_rdy1", bus.in_ready, 1'b1);
        tick();
        chk("t1_vld1", bus.out_valid, 4'b0010);
        drive(1'b1, 8'hA2, 2'b10);
        #1;
        chk("t1_rdy2", bus.in_ready, 1'b1);
        tick();
        chk("t1_vld2", bus.out_valid, 4'b0100);
        drive(1'b1, 8'hA3, 2'b11);
        #1;
        chk("t1_rdy3", bus.in_ready, 1'b1);
        tick();
        chk("t1_vld3", bus.out_valid, 4'b1000);
        drive(1'b0, 8'h00, 2'b00);
        tick();
        chk("t1_vldend", bus.out_valid, 4'b0000);
        chk("t1_out", {bus.out0, bus.out1, bus.out2, bus.out3}, 32'hA0A1A2A3);
        chk("t1_cnt", {bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3}, 32'h01010101);

        // ---- 2: backpressure on channel 1
        do_reset();
        bus.out_ready = 4'b1101;
        drive(1'b1, 8'h11, 2'b01);
        #1;
        chk("t2_rdy11", bus.in_ready, 1'b1);
        tick();
        chk("t2_vld11", bus.out_valid, 4'b0010);
        chk("t2_out11", bus.out1, 8'h11);
        drive(1'b1, 8'h22, 2'b01);
        #1;
        chk("t2_stall_a", bus.in_ready, 1'b0);
        tick();
        chk("t2_stall_b", bus.in_ready, 1'b0);
        chk("t2_hold11", bus.out1, 8'h11);
        chk("t2_holdvld", bus.out_valid, 4'b0010);
        bus.out_ready = 4'b1111;
        #1;
        chk("t2_release", bus.in_ready, 1'b1);
        tick();
        chk("t2_out22", bus.out1, 8'h22);
        chk("t2_vld22", bus.out_valid, 4'b0010);
        chk("t2_cnt1", bus.cnt1, 8'd1);
        drive(1'b1, 8'h33, 2'b10);
        #1;
        chk("t2_rdy33", bus.in_ready, 1'b1);
        tick();
        chk("t2_out33", bus.out2, 8'h33);
        chk("t2_vld33", bus.out_valid, 4'b0100);
        chk("t2_cnt1b", bus.cnt1, 8'd2);
        drive(1'b0, 8'h00, 2'b00);
        tick();
        chk("t2_cnt2", bus.cnt2, 8'd1);

        // ---- 3: simultaneous drain and reload on channel 3
        bus.out_ready = 4'b0000;
        drive(1'b1, 8'h55, 2'b11);
        tick();
        chk("t3_out55", bus.out3, 8'h55);
        bus.out_ready = 4'b1000;
        drive(1'b1, 8'h66, 2'b11);
        #1;
        chk("t3_rdy66", bus.in_ready, 1'b1);
        tick();
        chk("t3_out66", bus.out3, 8'h66);
        chk("t3_vld66", bus.out_valid, 4'b1000);
        chk("t3_cnt3", bus.cnt3, 8'd1);
        drive(1'b0, 8'h00, 2'b00);
        tick();
        chk("t3_cnt3b", bus.cnt3, 8'd2);
        chk("t3_vldend", bus.out_valid, 4'b0000);

        // ---- 5: reset mid-operation (counts are cnt1=2,cnt2=1,cnt3=2 here)
        bus.out_ready = 4'b0000;
        drive(1'b1, 8'hC0, 2'b00); tick();
        drive(1'b1, 8'hC1, 2'b01); tick();
        drive(1'b1, 8'hC2, 2'b10); tick();
        drive(1'b1, 8'hC3, 2'b11); tick();
        chk("t5_full", bus.out_valid, 4'b1111);
        chk("t5_cntpre", {bus.cnt1, bus.cnt3}, 16'h0202);
        drive(1'b1, 8'h5A, 2'b00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_vldrst", bus.out_valid, 4'b0000);
        chk("t5_cntrst", {bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3}, 32'h0);
        chk("t5_datrst", bus.out2, 8'h00);
        chk("t5_rdyrst", bus.in_ready, 1'b0);
        tick();
        chk("t5_stillrst", bus.out_valid, 4'b0000);
        #3;
        rst_n = 1'b1;
        #1;
        chk("t5_rdyrel", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("t5_vldrel", bus.out_valid, 4'b0001);
        chk("t5_out5a", bus.out0, 8'h5A);

        // ---- 4: counter wrap on channel 0
        drive(1'b0, 8'h00, 2'b00);
        do_reset();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i), 2'b00);
            tick();
        end
        chk("t4_cnt255", bus.cnt0, 8'hFF);
        drive(1'b0, 8'h00, 2'b00);
        tick();
        chk("t4_wrap", bus.cnt0, 8'h00);
        chk("t4_others", {bus.cnt1, bus.cnt2, bus.cnt3}, 24'h0);
        chk("t4_lastdat", bus.out0, 8'hFF);

        // ---- 6: held data after consume
        drive(1'b1, 8'h7E, 2'b10);
        tick();
        chk("t6_vld", bus.out_valid, 4'b0100);
        drive(1'b0, 8'h00, 2'b00);
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("t6_vldoff", bus.out_valid, 4'b0000);
        chk("t6_hold", bus.out2, 8'h7E);
        chk("t6_cnt2", bus.cnt2, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/demux1to4_seq.md
Name: demux1to4_seq

Overview:
- Registered 1-to-4 demultiplexer. It is the distribution counterpart of the team's 4-to-1 selectors.
- Routes a single valid/ready input stream to one of four output channels, chosen by the select pair {s0, s1}.
- Each output channel holds a one-entry register with its own valid/ready handshake and a transfer counter.
- Sits between a shared producer and four independent consumers.

Parameters:
- WIDTH, 8, data width of input and each output channel.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input data word.
- s0  input  1  select MSB.
- s1  input  1  select LSB.
- in_valid  input  1  in_data/s0/s1 valid this cycle.
- in_ready  output  1  block accepts the input word this cycle.
- out0, out1, out2, out3  output  WIDTH each  channel data registers.
- out_valid  output  4  bit N set: outN holds an unconsumed word.
- out_ready  input  4  bit N set: consumer N accepts outN this cycle.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  completed output transfers per channel.

Behaviour:
Reset:
- rst_n low asynchronously clears out0..out3, out_valid, and cnt0..cnt3 to 0.
- in_ready is 0 while rst_n is low.
- Reset mid-operation discards pending words immediately; no partial transfer survives.

Select decode:
- {s0,s1}: 2'b00 → channel 0, 2'b01 → 1, 2'b10 → 2, 2'b11 → 3.
- Select is sampled only when in_valid=1.
- In simulation, an X/Z on s0 or s1 forces in_ready=0 and nothing is captured.

Input acceptance (combinational):
- sel = decoded channel.
- in_ready = rst_n & (~out_valid[sel] | out_ready[sel]).
- This gives full throughput: one word per cycle into a channel whose consumer is ready.
- in_valid must stay high with stable in_data/s0/s1 until in_ready=1. The block does not check this; the bench does.

Input transfer:
- Occurs when in_valid & in_ready.
- Next edge: out<sel> <= in_data, out_valid[sel] <= 1.
- Latency is 1 cycle from input acceptance to out_valid.

Output transfer:
- Occurs when out_valid[N] & out_ready[N].
- Next edge: out_valid[N] <= 0, unless the same channel is reloaded in that cycle, in which case it stays 1 with the new data.
- outN data is not cleared after consumption; it holds the last value.

Channel independence:
- Only the selected channel's register changes on an input transfer.
- Outputs on all four channels may complete in the same cycle.
- A stalled channel (out_valid=1, out_ready=0) blocks in_ready only when it is the selected channel. Words for other channels still flow.
- There is no reordering: a word for a stalled channel waits at the input and blocks the head of line.

Counters:
- cntN increments by 1 on each output transfer of channel N.
- It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.

Other rules:
- out_ready[N] while out_valid[N]=0 has no effect.
- No combinational path from in_data to any output; data outputs are registered.

Test Plan:
1. Reset then basic routing.
   - Stimulus: assert rst_n low, release; all out_ready=4'b1111; send 8'hA0 to sel 00, 8'hA1 to 01, 8'hA2 to 10, 8'hA3 to 11 on consecutive cycles.
   - Response: out_valid shows one bit per cycle, 1 cycle after each accept; out0..out3 = A0..A3; cnt0..cnt3 = 1 each; in_ready high throughout.
2. Backpressure on one channel.
   - Stimulus: out_ready=4'b1101; send 8'h11 then 8'h22 to channel 1, then 8'h33 to channel 2.
   - Response: 8'h11 captured, out_valid[1] stays 1, in_ready=0 for the second word until out_ready[1] rises.
   - After release: 8'h22 is captured in that same cycle, out_valid[1] stays 1, cnt1=1; 8'h33 then reaches out2.
3. Simultaneous drain and reload.
   - Stimulus: channel 3 full with 8'h55 and out_ready[3]=1, in_valid with 8'h66 to sel 11 in the same cycle.
   - Response: out3=8'h66 with out_valid[3]=1 next cycle, no bubble, cnt3 +1.
4. Counter wrap.
   - Stimulus: CNT_W=8; 256 transfers to channel 0 with out_ready[0]=1.
   - Response: cnt0 returns to 0; cnt1..cnt3 stay 0.
5. Reset mid-operation.
   - Stimulus: all four channels loaded with out_ready=0; drop rst_n between clock edges.
   - Response: out_valid=4'b0000 and all cnt=0 immediately, before the next edge; in_ready=0 during reset; normal operation on the first edge after release.
6. Held data after consume.
   - Stimulus: deliver 8'h7E to channel 2 and consume it, then idle 5 cycles.
   - Response: out_valid[2]=0 and out2 still reads 8'h7E.
